bus_activity_monitor: RTL and testbench
=======================================

# bus_activity_monitor

Watches the raw intercepted bus lines and produces the `comm_active` qualifier consumed by the I/O handler's activity LED, plus a saturating count of bus-activity cycles for debug. It sits between the bus pins and the I/O handler and is the only producer of `comm_active`. It synchronises asynchronous lines, detects edges, rejects isolated glitches and holds activity asserted until the bus has been quiet for a programmable timeout.

## Interface
- `NUM_LINES`, 4: number of monitored bus lines.
- `IDLE_LEVEL`, all ones (`NUM_LINES` bits): idle level of each line, loaded into the synchroniser on reset.
- `IDLE_TIMEOUT`, 1200: quiet cycles before deassertion (100 µs at 12 MHz); must be ≥ 2.
- `MIN_EDGES`, 2: edge cycles required within one timeout window to qualify activity; must be ≥ 1.
- `CNT_WIDTH`, 16: width of `edge_count`.

Ports:
- `sys_clk`  in  1: system clock, single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `bus_lines`  in  `NUM_LINES`: asynchronous raw bus lines.
- `clear_count`  in  1: synchronous clear of `edge_count`.
- `comm_active`  out  1: high while the bus is active; registered.
- `edge_count`  out  `CNT_WIDTH`: saturating count of edge cycles; registered.

## Operation
- Each line passes through a 2-FF synchroniser (`s1`, `s2`) followed by a history register `prev`. On reset all three load `IDLE_LEVEL`, so an idle bus produces no spurious edge.
- `edge = |(s2 ^ prev)` (combinational). One cycle with any number of toggling lines counts as one edge cycle.
- FSM states (reset → IDLE):
  - IDLE: on `edge`, if `MIN_EDGES` = 1 go to ACTIVE; otherwise go to ARMED with `qual_cnt` = 1 and `quiet` = 0.
  - ARMED: on `edge`, `qual_cnt` increments and `quiet` clears; when `qual_cnt` reaches `MIN_EDGES`, go to ACTIVE. Without an edge, `quiet` increments; at `quiet` = `IDLE_TIMEOUT`-1, go to IDLE.
  - ACTIVE: `edge` clears `quiet`; otherwise `quiet` increments; at `quiet` = `IDLE_TIMEOUT`-1 with no edge, go to IDLE.
- `comm_active` is 1 only in ACTIVE.
- `edge_count` increments by 1 on each `edge` cycle and saturates at 2^`CNT_WIDTH`-1. `clear_count` forces it to 0; when clear and edge coincide, clear wins and the result is 0.
- `quiet` is wide enough for `IDLE_TIMEOUT`; `qual_cnt` is wide enough for `MIN_EDGES`.
- Reset values: `comm_active` = 0, `edge_count` = 0, state = IDLE, counters = 0.

## Timing
- An input change sampled into `s1` at edge k appears in `s2` at k+1; `edge` is true during the cycle following k+1; FSM and counters register it at k+2.
- With `MIN_EDGES` = 1, `comm_active` rises at edge k+2.
- Let E be the last clock edge that registers an `edge` while ACTIVE. `comm_active` falls at edge E+`IDLE_TIMEOUT`, provided no further edge occurs.
- Edge coinciding with timeout: the edge wins, the FSM stays or moves forward, and `quiet` clears.
- Reset mid-operation clears the synchronisers, FSM and counters at that edge; `comm_active` is 0 on the next cycle.
- A line held at a new static level produces exactly one edge cycle.

## Configuration
- `BUS_MONITOR_GLITCH_FILTER_EN` defined: ARMED state and `qual_cnt` are present; behaviour is as above.
- `BUS_MONITOR_GLITCH_FILTER_EN` undefined: ARMED and `qual_cnt` are removed, `MIN_EDGES` is ignored, and any single edge cycle moves IDLE → ACTIVE (latency k+2). The ACTIVE timeout and `edge_count` are unchanged.

## Test plan
Bench configuration: `NUM_LINES`=4, `IDLE_LEVEL`=4'hF, `IDLE_TIMEOUT`=16, `MIN_EDGES`=3, filter enabled unless stated.
- Reset and idle: `bus_lines` = 4'hF for 100 cycles → `comm_active` = 0, `edge_count` = 0 throughout.
- Glitch rejection: a 2-cycle low pulse on line 0 (2 edge cycles), then quiet → state goes ARMED, then IDLE 16 cycles after the second edge; `comm_active` never asserts; `edge_count` = 2.
- Activation and hold: toggle line 2 every 4 cycles, 6 times → `comm_active` rises 2 edges after the third sampled toggle and falls exactly 16 cycles after the last registered edge; `edge_count` = 6.
- Simultaneous and coincident events: all 4 lines toggle in one cycle → `edge_count` += 1. Edge arrives at `quiet` = 15 → `comm_active` stays 1. `clear_count` in the same cycle as an edge → `edge_count` = 0.
- Saturation and reset: with `CNT_WIDTH`=4, apply 20 edge cycles → `edge_count` holds at 15. Assert `rst` while ACTIVE → next cycle `comm_active` = 0 and `edge_count` = 0.
- Filter compiled out: a single toggle on line 1 → `comm_active` = 1 at edge k+2 and 0 sixteen cycles later.

Source files
------------

// File: rtl/bus_activity_monitor.sv
// Bus activity monitor: line sync, edge detect, glitch filter, idle timeout.
// Optional glitch filter (ARMED state, qual_cnt): BUS_MONITOR_GLITCH_FILTER_EN.

module bus_activity_monitor #(
    parameter int                   NUM_LINES    = 4,
    parameter logic [NUM_LINES-1:0] IDLE_LEVEL   = '1,
    parameter int                   IDLE_TIMEOUT = 1200,
    parameter int                   MIN_EDGES    = 2,
    parameter int                   CNT_WIDTH    = 16
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic [NUM_LINES-1:0] bus_lines,
    input  logic                 clear_count,
    output logic                 comm_active,
    output logic [CNT_WIDTH-1:0] edge_count
);

    localparam int QW = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(IDLE_TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd2;
`ifdef BUS_MONITOR_GLITCH_FILTER_EN
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam int QCW = $clog2(MIN_EDGES + 1);
    localparam logic [QCW-1:0] Q_MIN = QCW'(MIN_EDGES);
`endif

    if (IDLE_TIMEOUT < 2 || MIN_EDGES < 1) begin : g_cfg_check
        $error("bus_activity_monitor: IDLE_TIMEOUT must be >= 2, MIN_EDGES >= 1");
    end

    logic [NUM_LINES-1:0] s1, s2, prev;
    logic                 bus_edge;
    logic [1:0]           state, state_nxt;
    logic [QW-1:0]        quiet, quiet_nxt;
`ifdef BUS_MONITOR_GLITCH_FILTER_EN
    logic [QCW-1:0]       qual_cnt, qual_nxt;
`endif

    // prev shares the idle reset level so a quiet bus shows no edge
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            s1   <= IDLE_LEVEL;
            s2   <= IDLE_LEVEL;
            prev <= IDLE_LEVEL;
        end else begin
            s1   <= bus_lines;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign bus_edge = |(s2 ^ prev);

    always_comb begin
        state_nxt = state;
        quiet_nxt = quiet;
`ifdef BUS_MONITOR_GLITCH_FILTER_EN
        qual_nxt  = qual_cnt;
`endif
        case (state)
            S_IDLE: begin
                quiet_nxt = '0;
`ifdef BUS_MONITOR_GLITCH_FILTER_EN
                qual_nxt  = '0;
                if (bus_edge) begin
                    if (MIN_EDGES == 1) begin
                        state_nxt = S_ACTIVE;
                    end else begin
                        state_nxt = S_ARMED;
                        qual_nxt  = QCW'(1);
                    end
                end
`else
                if (bus_edge) state_nxt = S_ACTIVE;
`endif
            end
`ifdef BUS_MONITOR_GLITCH_FILTER_EN
            S_ARMED: begin
                if (bus_edge) begin
                    qual_nxt  = qual_cnt + 1'b1;
                    quiet_nxt = '0;
                    if (qual_nxt == Q_MIN) state_nxt = S_ACTIVE;
                end else if (quiet == Q_LAST) begin
                    state_nxt = S_IDLE;
                    quiet_nxt = '0;
                end else begin
                    quiet_nxt = quiet + 1'b1;
                end
            end
`endif
            S_ACTIVE: begin
                if (bus_edge) begin
                    quiet_nxt = '0;
                end else if (quiet == Q_LAST) begin
                    state_nxt = S_IDLE;
                    quiet_nxt = '0;
                end else begin
                    quiet_nxt = quiet + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                quiet_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state       <= S_IDLE;
            quiet       <= '0;
            comm_active <= 1'b0;
`ifdef BUS_MONITOR_GLITCH_FILTER_EN
            qual_cnt    <= '0;
`endif
        end else begin
            state       <= state_nxt;
            quiet       <= quiet_nxt;
            comm_active <= (state_nxt == S_ACTIVE);
`ifdef BUS_MONITOR_GLITCH_FILTER_EN
            qual_cnt    <= qual_nxt;
`endif
        end
    end

    // clear has priority over a coincident edge
    always_ff @(posedge sys_clk) begin
        if (rst || clear_count) begin
            edge_count <= '0;
        end else if (bus_edge && (edge_count != '1)) begin
            edge_count <= edge_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_activity_monitor.sv
// Bench for bus_activity_monitor: per-cycle scoreboard plus directed checks.
// Follows BUS_MONITOR_GLITCH_FILTER_EN the same way the design does.

module tb_bus_activity_monitor;

    localparam int TO   = 16;
    localparam int CW   = 4;
`ifdef BUS_MONITOR_GLITCH_FILTER_EN
    localparam int MINE = 3;
`else
    localparam int MINE = 1;
`endif

    logic          sys_clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    bus_lines = 4'hF;
    logic          clear_count = 1'b0;
    logic          comm_active;
    logic [CW-1:0] edge_count;

    bus_activity_monitor #(
        .NUM_LINES   (4),
        .IDLE_LEVEL  (4'hF),
        .IDLE_TIMEOUT(TO),
        .MIN_EDGES   (3),
        .CNT_WIDTH   (CW)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .bus_lines  (bus_lines),
        .clear_count(clear_count),
        .comm_active(comm_active),
        .edge_count (edge_count)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic          act;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference: sampled-input history and burst bookkeeping
    logic [3:0]    h0 = 4'hF, h1 = 4'hF, h2 = 4'hF;
    int            burst_n = 0;
    int            since = TO;
    logic [CW-1:0] m_cnt = '0;
    logic [3:0]    cur = 4'hF;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // predict DUT outputs after the coming clock edge
    task automatic model_step(input logic [3:0] l, input logic c,
                              input logic r);
        logic e;
        exp_t x;
        if (r) begin
            h0 = 4'hF; h1 = 4'hF; h2 = 4'hF;
            burst_n = 0;
            since = TO;
            m_cnt = '0;
        end else begin
            e  = (h1 != h2);
            h2 = h1; h1 = h0; h0 = l;
            if (e) begin
                burst_n = (burst_n > 0 && since < TO) ? burst_n + 1 : 1;
                since = 0;
            end else if (since < TO) begin
                since++;
            end
            if (c) m_cnt = '0;
            else if (e && m_cnt != '1) m_cnt = m_cnt + 1'b1;
        end
        x.act = (burst_n >= MINE) && (since < TO);
        x.cnt = m_cnt;
        sb.push_back(x);
    endtask

    task automatic tick(input logic [3:0] l, input logic c, input logic r);
        exp_t x;
        bus_lines   = l;
        clear_count = c;
        rst         = r;
        model_step(l, c, r);
        @(posedge sys_clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 16'd0, 16'd1);
        end else begin
            x = sb.pop_front();
            check("comm_active", 16'(comm_active), 16'(x.act));
            check("edge_count", 16'(edge_count), 16'(x.cnt));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(cur, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) tick(4'hF, 1'b0, 1'b1);
        check("rst_active", 16'(comm_active), 16'd0);
        check("rst_count", 16'(edge_count), 16'd0);

        idle(100);
        check("idle_count", 16'(edge_count), 16'd0);

        // glitch: two-cycle low pulse on line 0
        tick(4'hE, 1'b0, 1'b0);
        tick(4'hE, 1'b0, 1'b0);
        idle(30);
        check("glitch_count", 16'(edge_count), 16'd2);
`ifdef BUS_MONITOR_GLITCH_FILTER_EN
        check("glitch_active", 16'(comm_active), 16'd0);
`endif
        tick(cur, 1'b1, 1'b0);

        // line 2 toggles every 4 cycles, six times
        for (int i = 0; i < 6; i++) begin
            cur ^= 4'h4;
            tick(cur, 1'b0, 1'b0);
            if (i < 5) begin
                for (int j = 1; j <= 3; j++) begin
                    tick(cur, 1'b0, 1'b0);
                    if (i == 2 && j == 2)
                        check("rise_k2", 16'(comm_active), 16'd1);
                end
            end else begin
                for (int j = 1; j <= 20; j++) begin
                    tick(cur, 1'b0, 1'b0);
                    if (j == 17) check("hold_e15", 16'(comm_active), 16'd1);
                    if (j == 18) check("fall_e16", 16'(comm_active), 16'd0);
                end
            end
        end
        check("toggle_count", 16'(edge_count), 16'd6);
        tick(cur, 1'b1, 1'b0);

        // all lines toggle together: one edge cycle
        cur ^= 4'hF;
        tick(cur, 1'b0, 1'b0);
        idle(2);
        check("simul_count", 16'(edge_count), 16'd1);
        cur ^= 4'h8;
        tick(cur, 1'b0, 1'b0);
        tick(cur, 1'b0, 1'b0);
        cur ^= 4'h8;
        tick(cur, 1'b0, 1'b0);
        idle(15);
        // next edge lands exactly when quiet = 15
        cur ^= 4'h8;
        tick(cur, 1'b0, 1'b0);
        idle(2);
        check("coincide_active", 16'(comm_active), 16'd1);

        // clear in the cycle the edge registers
        tick(cur, 1'b1, 1'b0);
        cur ^= 4'h1;
        tick(cur, 1'b0, 1'b0);
        tick(cur, 1'b0, 1'b0);
        tick(cur, 1'b1, 1'b0);
        check("clear_wins", 16'(edge_count), 16'd0);
        idle(3);

        // saturation: 20 consecutive edge cycles
        for (int i = 0; i < 20; i++) begin
            cur ^= 4'h2;
            tick(cur, 1'b0, 1'b0);
        end
        idle(3);
        check("sat_count", 16'(edge_count), 16'd15);
        check("sat_active", 16'(comm_active), 16'd1);

        tick(cur, 1'b0, 1'b1);
        check("rst_mid_active", 16'(comm_active), 16'd0);
        check("rst_mid_count", 16'(edge_count), 16'd0);
        cur = 4'hF;
        idle(40);

`ifndef BUS_MONITOR_GLITCH_FILTER_EN
        tick(cur, 1'b1, 1'b0);
        cur ^= 4'h2;
        tick(cur, 1'b0, 1'b0);
        tick(cur, 1'b0, 1'b0);
        check("nofilt_k1", 16'(comm_active), 16'd0);
        tick(cur, 1'b0, 1'b0);
        check("nofilt_k2", 16'(comm_active), 16'd1);
        idle(15);
        check("nofilt_hold", 16'(comm_active), 16'd1);
        idle(1);
        check("nofilt_fall", 16'(comm_active), 16'd0);
        idle(5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
